// File: rtl/fp_pkg.sv
// Shared fixed-point helpers: word-width math, default Q format, compare.
// Reused across the FP datapath blocks.
package fp_pkg;

  localparam int FP_INTEGER  = 2;
  localparam int FP_FRACTION = 14;
  localparam int FP_XW       = 64;

  function automatic int fp_dw(input int i, input int f);
    return i + f;
  endfunction

  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Operands arrive already sign- or zero-extended to FP_XW bits.
  function automatic logic gt(
    input logic [FP_XW-1:0] a,
    input logic [FP_XW-1:0] b,
    input logic             signed_mode
  );
    if (signed_mode)
      return $signed(a) > $signed(b);
    else
      return a > b;
  endfunction

endpackage

// File: rtl/fp_max_lane.sv
// One lane of the max reducer: running max, output register, optional argmax.
// Argmax index register present only with FP_MAX_POOL_ARGMAX_EN.
module fp_max_lane import fp_pkg::*; #(
  parameter int SIGNED = 1,
  parameter int DW     = 16,
  parameter int IW     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          take,
  input  logic          first,
  input  logic          fire,
`ifdef FP_MAX_POOL_ARGMAX_EN
  input  logic [IW-1:0] pos,
  output logic [IW-1:0] out_index,
`endif
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0]    acc;
  logic [DW-1:0]    nxt;
  logic [FP_XW-1:0] in_x;
  logic [FP_XW-1:0] acc_x;
  logic             upd;

  assign in_x  = (SIGNED != 0) ? FP_XW'($signed(in_data))
                               : FP_XW'(in_data);
  assign acc_x = (SIGNED != 0) ? FP_XW'($signed(acc))
                               : FP_XW'(acc);

  // Strict compare: ties keep the earlier beat.
  always_comb begin
    upd = first || gt(in_x, acc_x, SIGNED != 0);
    nxt = upd ? in_data : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      out_data <= '0;
    end else begin
      if (take) acc <= nxt;
      if (fire) out_data <= nxt;
    end
  end

`ifdef FP_MAX_POOL_ARGMAX_EN
  logic [IW-1:0] acc_idx;
  logic [IW-1:0] nxt_idx;

  assign nxt_idx = upd ? pos : acc_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_idx   <= '0;
      out_index <= '0;
    end else begin
      if (take) acc_idx <= nxt_idx;
      if (fire) out_index <= nxt_idx;
    end
  end
`endif

endmodule

// File: rtl/fp_max_pool_stream.sv
// Streaming multi-lane fixed-point max pool with valid/ready on both sides.
// Optional argmax output via FP_MAX_POOL_ARGMAX_EN.
module fp_max_pool_stream import fp_pkg::*; #(
  parameter  int SIGNED   = 1,
  parameter  int INTEGER  = FP_INTEGER,
  parameter  int FRACTION = FP_FRACTION,
  parameter  int CHANNELS = 4,
  parameter  int WINDOW   = 4,
  localparam int DW       = fp_dw(INTEGER, FRACTION),
  localparam int CW       = idx_w(WINDOW)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHANNELS*DW-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef FP_MAX_POOL_ARGMAX_EN
  output logic [CHANNELS*CW-1:0] out_index,
`endif
  output logic [CHANNELS*DW-1:0] out_data
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          take;
  logic          first;
  logic          last;
  logic          fire;

  // HOLD means a result is parked; it only blocks input if not drained now.
  assign in_ready = (state == ACCUM) || out_ready;
  assign take     = in_valid && in_ready;
  assign first    = (cnt == '0);
  assign last     = (cnt == CW'(WINDOW - 1));
  assign fire     = take && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      if (take)
        cnt <= last ? '0 : cnt + CW'(1);
      if (fire) begin
        state     <= HOLD;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        state     <= ACCUM;
        out_valid <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    fp_max_lane #(
      .SIGNED (SIGNED),
      .DW     (DW),
      .IW     (CW)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .take      (take),
      .first     (first),
      .fire      (fire),
`ifdef FP_MAX_POOL_ARGMAX_EN
      .pos       (cnt),
      .out_index (out_index[c*CW +: CW]),
`endif
      .in_data   (in_data[c*DW +: DW]),
      .out_data  (out_data[c*DW +: DW])
    );
  end

endmodule

// File: tb/tb_fp_max_pool_stream.sv
// Bench for fp_max_pool_stream: signed and unsigned instances, 4 lanes,
// window 4, scoreboard queues checked at every output handshake.
module tb_fp_max_pool_stream;

  localparam int CH = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  typedef logic [CH*DW-1:0] beats_t [4];
  typedef struct {
    logic [CH*DW-1:0] data;
    logic [CH*IW-1:0] idx;
  } exp_t;

  logic             clk = 0;
  logic             rst = 1;
  logic             in_valid = 0;
  logic [CH*DW-1:0] in_data = '0;
  logic             out_ready = 1;
  logic             ir_s, ir_u, ov_s, ov_u;
  logic [CH*DW-1:0] od_s, od_u;
`ifdef FP_MAX_POOL_ARGMAX_EN
  logic [CH*IW-1:0] oi_s, oi_u;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t q_s[$];
  exp_t q_u[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_max_pool_stream #(.SIGNED(1), .CHANNELS(CH), .WINDOW(4)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (ir_s),
    .in_data   (in_data),
    .out_valid (ov_s),
    .out_ready (out_ready),
`ifdef FP_MAX_POOL_ARGMAX_EN
    .out_index (oi_s),
`endif
    .out_data  (od_s)
  );

  fp_max_pool_stream #(.SIGNED(0), .CHANNELS(CH), .WINDOW(4)) dut_u (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (ir_u),
    .in_data   (in_data),
    .out_valid (ov_u),
    .out_ready (out_ready),
`ifdef FP_MAX_POOL_ARGMAX_EN
    .out_index (oi_u),
`endif
    .out_data  (od_u)
  );

  function automatic exp_t model(input beats_t b, input bit sgn);
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      logic [DW-1:0] best;
      logic [IW-1:0] bi;
      best = b[0][c*DW +: DW];
      bi   = '0;
      for (int k = 1; k < 4; k++) begin
        logic [DW-1:0] v;
        v = b[k][c*DW +: DW];
        if (sgn ? ($signed(v) > $signed(best)) : (v > best)) begin
          best = v;
          bi   = IW'(k);
        end
      end
      e.data[c*DW +: DW] = best;
      e.idx[c*IW +: IW]  = bi;
    end
    return e;
  endfunction

  // Scoreboard: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (ov_s) begin
        vectors++;
        if (q_s.size() == 0) begin
          miscompares++;
          $display("FAIL sb_s: got output %h, required none", od_s);
        end else begin
          exp_t e;
          e = q_s.pop_front();
          if (od_s !== e.data) begin
            miscompares++;
            $display("FAIL sb_s data: got %h, required %h", od_s, e.data);
          end
`ifdef FP_MAX_POOL_ARGMAX_EN
          vectors++;
          if (oi_s !== e.idx) begin
            miscompares++;
            $display("FAIL sb_s idx: got %h, required %h", oi_s, e.idx);
          end
`endif
        end
      end
      if (ov_u) begin
        vectors++;
        if (q_u.size() == 0) begin
          miscompares++;
          $display("FAIL sb_u: got output %h, required none", od_u);
        end else begin
          exp_t e;
          e = q_u.pop_front();
          if (od_u !== e.data) begin
            miscompares++;
            $display("FAIL sb_u data: got %h, required %h", od_u, e.data);
          end
`ifdef FP_MAX_POOL_ARGMAX_EN
          vectors++;
          if (oi_u !== e.idx) begin
            miscompares++;
            $display("FAIL sb_u idx: got %h, required %h", oi_u, e.idx);
          end
`endif
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [CH*DW-1:0] d);
    int n;
    in_valid = 1;
    in_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (ir_s) break;
      n++;
      if (n > 50) begin
        miscompares++;
        $display("FAIL send_beat timeout: in_ready 0, required 1");
        $fatal(1, "stuck");
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input beats_t b);
    q_s.push_back(model(b, 1'b1));
    q_u.push_back(model(b, 1'b0));
  endtask

  task automatic send_window(input beats_t b);
    for (int k = 0; k < 4; k++) send_beat(b[k]);
    push_expected(b);
  endtask

  function automatic beats_t rand_beats();
    beats_t b;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < CH; c++)
        b[k][c*DW +: DW] = DW'($urandom);
    return b;
  endfunction

  task automatic test_reset();
    rst = 1;
    in_valid = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    vectors++;
    if (ov_s !== 1'b0 || ov_u !== 1'b0) begin
      miscompares++;
      $display("FAIL reset out_valid: got %b%b, required 00", ov_s, ov_u);
    end
    vectors++;
    if (od_s !== '0 || od_u !== '0) begin
      miscompares++;
      $display("FAIL reset out_data: got %h %h, required 0", od_s, od_u);
    end
    vectors++;
    if (ir_s !== 1'b1 || ir_u !== 1'b1) begin
      miscompares++;
      $display("FAIL reset in_ready: got %b%b, required 11", ir_s, ir_u);
    end
`ifdef FP_MAX_POOL_ARGMAX_EN
    vectors++;
    if (oi_s !== '0 || oi_u !== '0) begin
      miscompares++;
      $display("FAIL reset out_index: got %h %h, required 0", oi_s, oi_u);
    end
`endif
  endtask

  task automatic test_signedness();
    beats_t b;
    logic [15:0] l0 [4];
    @(posedge clk); #1;
    l0[0] = 16'hC000; l0[1] = 16'h2000;
    l0[2] = 16'h4000; l0[3] = 16'h1000;
    b = rand_beats();
    for (int k = 0; k < 4; k++) b[k][15:0] = l0[k];
    for (int k = 0; k < 3; k++) send_beat(b[k]);
    vectors++;
    if (ov_s !== 1'b0) begin
      miscompares++;
      $display("FAIL early out_valid: got %b, required 0", ov_s);
    end
    send_beat(b[3]);
    push_expected(b);
    vectors++;
    if (ov_s !== 1'b1 || ov_u !== 1'b1) begin
      miscompares++;
      $display("FAIL latency out_valid: got %b%b, required 11", ov_s, ov_u);
    end
    vectors++;
    if (od_s[15:0] !== 16'h4000) begin
      miscompares++;
      $display("FAIL signed max: got %h, required 4000", od_s[15:0]);
    end
    vectors++;
    if (od_u[15:0] !== 16'hC000) begin
      miscompares++;
      $display("FAIL unsigned max: got %h, required c000", od_u[15:0]);
    end
`ifdef FP_MAX_POOL_ARGMAX_EN
    vectors++;
    if (oi_s[1:0] !== 2'd2 || oi_u[1:0] !== 2'd0) begin
      miscompares++;
      $display("FAIL argmax: got %0d %0d, required 2 0", oi_s[1:0], oi_u[1:0]);
    end
`endif
    in_valid = 0;
  endtask

  task automatic test_ties();
    beats_t b;
    @(posedge clk); #1;
    b[0] = {CH{16'h4000}};
    b[1] = {CH{16'h4000}};
    b[2] = {CH{16'h0000}};
    b[3] = {CH{16'h4000}};
    send_window(b);
    vectors++;
    if (od_s !== {CH{16'h4000}} || od_u !== {CH{16'h4000}}) begin
      miscompares++;
      $display("FAIL ties data: got %h %h, required 4000s", od_s, od_u);
    end
`ifdef FP_MAX_POOL_ARGMAX_EN
    vectors++;
    if (oi_s !== '0 || oi_u !== '0) begin
      miscompares++;
      $display("FAIL ties idx: got %h %h, required 0", oi_s, oi_u);
    end
`endif
    in_valid = 0;
  endtask

  task automatic test_backpressure();
    beats_t a, b;
    exp_t ea;
    @(posedge clk); #1;
    out_ready = 0;
    a = rand_beats();
    b = rand_beats();
    b[0] = {CH{16'h3FFF}};
    send_window(a);
    ea = q_s[q_s.size()-1];
    in_valid = 1;
    in_data  = b[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (ir_s !== 1'b0 || ov_s !== 1'b1 || od_s !== ea.data) begin
        miscompares++;
        $display("FAIL backpressure: ready %b valid %b data %h, required 0 1 %h",
                 ir_s, ov_s, od_s, ea.data);
      end
    end
    @(posedge clk); #1;
    out_ready = 1;
    send_window(b);
    in_valid = 0;
  endtask

  task automatic test_back_to_back();
    int t0;
    @(posedge clk); #1;
    out_ready = 1;
    t0 = cyc;
    for (int w = 0; w < 3; w++) begin
      send_window(rand_beats());
      vectors++;
      if (cyc - t0 != 4 * (w + 1) || ov_s !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b window %0d: cycle %0d valid %b, required %0d 1",
                 w, cyc - t0, ov_s, 4 * (w + 1));
      end
    end
    in_valid = 0;
  endtask

  task automatic test_reset_mid();
    beats_t b;
    @(posedge clk); #1;
    send_beat({CH{16'h7000}});
    send_beat({CH{16'h7000}});
    in_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 4; k++) b[k] = {CH{16'(16'h0100 * (k + 1))}};
    send_window(b);
    vectors++;
    if (od_s !== {CH{16'h0400}} || od_u !== {CH{16'h0400}}) begin
      miscompares++;
      $display("FAIL reset_mid data: got %h %h, required 0400s", od_s, od_u);
    end
    in_valid = 0;
    @(posedge clk); #1;
    out_ready = 0;
    send_window(rand_beats());
    in_valid = 0;
    void'(q_s.pop_back());
    void'(q_u.pop_back());
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    out_ready = 1;
    @(negedge clk);
    vectors++;
    if (ov_s !== 1'b0 || ov_u !== 1'b0 || od_s !== '0) begin
      miscompares++;
      $display("FAIL drop pending: valid %b%b data %h, required 00 0",
               ov_s, ov_u, od_s);
    end
  endtask

  initial begin
    test_reset();
    test_signedness();
    test_ties();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(posedge clk);
    vectors++;
    if (q_s.size() != 0 || q_u.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d %0d results outstanding, required 0",
               q_s.size(), q_u.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
